debug_uart_tx: RTL and testbench

//  Transmitting end of the CPU debug-port link. Snapshots the seven 8-bit debug_port

---
 rtl/debug_uart_tx.sv | 170 +++++++++++++++++
 tb/tb_debug_uart_tx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/debug_uart_tx.sv
// Debug-port UART transmitter: snapshots seven debug bytes on request and sends
// them as one 8N1 frame (SYNC, D1..D7, CHK) on the tx line.
module debug_uart_tx #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       start,
    input  logic [7:0] debug_port1,
    input  logic [7:0] debug_port2,
    input  logic [7:0] debug_port3,
    input  logic [7:0] debug_port4,
    input  logic [7:0] debug_port5,
    input  logic [7:0] debug_port6,
    input  logic [7:0] debug_port7,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  baud_q, baud_d;
    logic [2:0]     bit_q, bit_d;
    logic [3:0]     byte_q, byte_d;
    logic [7:0]     shadow_q [0:6];
    logic [7:0]     shadow_d [0:6];
    logic [7:0]     chk_q, chk_d;
    logic           tx_q, tx_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [7:0]     port_in [0:6];
    logic [7:0]     port_sum;
    logic [7:0]     cur_byte;
    logic [2:0]     sh_idx;
    logic [2:0]     bit_nxt;
    logic           baud_wrap;

    assign port_in[0] = debug_port1;
    assign port_in[1] = debug_port2;
    assign port_in[2] = debug_port3;
    assign port_in[3] = debug_port4;
    assign port_in[4] = debug_port5;
    assign port_in[5] = debug_port6;
    assign port_in[6] = debug_port7;

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

    assign baud_wrap = (baud_q == CW'(CLKS_PER_BIT - 1));
    assign sh_idx    = byte_q[2:0] - 3'd1;
    assign bit_nxt   = bit_q + 3'd1;

    always_comb begin
        port_sum = 8'd0;
        for (int i = 0; i < 7; i++) begin
            port_sum = port_sum + port_in[i];
        end
    end

    // Byte 0 is the sync marker, byte 8 the checksum, 1..7 the captured payload.
    always_comb begin
        if (byte_q == 4'd0) begin
            cur_byte = SYNC_BYTE;
        end else if (byte_q == 4'd8) begin
            cur_byte = chk_q;
        end else begin
            cur_byte = shadow_q[sh_idx];
        end
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_wrap ? '0 : baud_q + CW'(1);
        bit_d    = bit_q;
        byte_d   = byte_q;
        shadow_d = shadow_q;
        chk_d    = chk_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (start) begin
                    shadow_d = port_in;
                    chk_d    = 8'd0 - port_sum;
                    state_d  = START;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                    byte_d   = 4'd0;
                    bit_d    = 3'd0;
                end
            end
            START: begin
                if (baud_wrap) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    tx_d    = cur_byte[0];
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_nxt;
                        tx_d  = cur_byte[bit_nxt];
                    end
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    if (byte_q != 4'd8) begin
                        byte_d  = byte_q + 4'd1;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 4'd0;
            chk_q   <= 8'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < 7; i++) begin
                shadow_q[i] <= 8'd0;
            end
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            chk_q    <= chk_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            shadow_q <= shadow_d;
        end
    end

endmodule

// File: tb/tb_debug_uart_tx.sv
// Directed bench for debug_uart_tx: a mid-bit UART monitor decodes each frame and
// compares it against hand-computed bytes.
module tb_debug_uart_tx;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dp [7];
    logic       tx, busy, done;

    int n_compared = 0;
    int n_mismatched = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int high_run = 0;
    int gap_q [$];

    always #5 clk = ~clk;

    debug_uart_tx #(.CLKS_PER_BIT(N), .SYNC_BYTE(8'hA5)) dut (
        .clk         (clk),
        .nreset      (nreset),
        .start       (start),
        .debug_port1 (dp[0]),
        .debug_port2 (dp[1]),
        .debug_port3 (dp[2]),
        .debug_port4 (dp[3]),
        .debug_port5 (dp[4]),
        .debug_port6 (dp[5]),
        .debug_port7 (dp[6]),
        .tx          (tx),
        .busy        (busy),
        .done        (done)
    );

    // Cycle counters and a log of each high run on tx ending at a falling edge.
    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt = busy_cnt + 1;
        if (done === 1'b1) done_cnt = done_cnt + 1;
        if (tx === 1'b1) begin
            high_run = high_run + 1;
        end else begin
            if (high_run != 0) gap_q.push_back(high_run);
            high_run = 0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared = n_compared + 1;
        if (got !== exp) begin
            n_mismatched = n_mismatched + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_ports(input logic [6:0][7:0] p);
        for (int i = 0; i < 7; i++) dp[i] = p[i];
    endtask

    function automatic logic [8:0][7:0] build_frame(input logic [6:0][7:0] p, input logic [7:0] chk);
        logic [8:0][7:0] f;
        f[0] = 8'hA5;
        for (int i = 0; i < 7; i++) f[i+1] = p[i];
        f[8] = chk;
        return f;
    endfunction

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Called on a negedge; decodes 9 bytes sampling in the middle of each bit.
    task automatic recv_frame(input string tag, input logic [8:0][7:0] exp);
        logic [7:0] data;
        string      line;
        line = "";
        for (int b = 0; b < 9; b++) begin
            int t;
            int lim;
            t = 0;
            lim = (b == 0) ? 400 : 20;
            while (tx !== 1'b0 && t < lim) begin
                @(negedge clk);
                t++;
            end
            if (tx !== 1'b0) begin
                check_eq($sformatf("%s_byte%0d_start_timeout", tag, b), 32'd0, 32'd1);
                return;
            end
            repeat (N/2) @(negedge clk);
            check_eq($sformatf("%s_byte%0d_startbit", tag, b), {31'd0, tx}, 32'd0);
            data = 8'd0;
            for (int k = 0; k < 8; k++) begin
                repeat (N) @(negedge clk);
                data[k] = tx;
            end
            repeat (N) @(negedge clk);
            check_eq($sformatf("%s_byte%0d_stopbit", tag, b), {31'd0, tx}, 32'd1);
            check_eq($sformatf("%s_byte%0d", tag, b), {24'd0, data}, {24'd0, exp[b]});
            line = {line, $sformatf(" %02h", data)};
        end
        $display("frame %s:%s", tag, line);
    endtask

    logic [6:0][7:0] p_seq, p_ff, p_zero, p_aa, p_tens;
    int b0, d0, idx;

    initial begin
        p_seq  = {8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        p_ff   = {7{8'hFF}};
        p_zero = {7{8'h00}};
        p_aa   = {7{8'hAA}};
        p_tens = {8'h70, 8'h60, 8'h50, 8'h40, 8'h30, 8'h20, 8'h10};
        set_ports(p_zero);

        // 1: reset state, then idle line after release
        repeat (3) @(negedge clk);
        check_eq("rst_tx", {31'd0, tx}, 32'd1);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        nreset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq($sformatf("idle_tx_%0d", i), {31'd0, tx}, 32'd1);
        end

        // 2: basic frame, busy length and single done pulse
        set_ports(p_seq);
        b0 = busy_cnt;
        d0 = done_cnt;
        pulse_start();
        recv_frame("seq", build_frame(p_seq, 8'hE4));
        repeat (10) @(negedge clk);
        check_eq("seq_busy_cycles", busy_cnt - b0, 32'd360);
        check_eq("seq_done_pulses", done_cnt - d0, 32'd1);

        // 3: checksum corner values
        set_ports(p_ff);
        pulse_start();
        recv_frame("all_ff", build_frame(p_ff, 8'h07));
        repeat (5) @(negedge clk);
        set_ports(p_zero);
        pulse_start();
        recv_frame("all_00", build_frame(p_zero, 8'h00));
        repeat (5) @(negedge clk);

        // 4: ports change and start pulses mid-frame
        set_ports(p_seq);
        b0 = busy_cnt;
        d0 = done_cnt;
        pulse_start();
        fork
            recv_frame("midchg", build_frame(p_seq, 8'hE4));
            begin
                repeat (50) @(negedge clk);
                set_ports(p_aa);
                start = 1'b1;
                @(negedge clk) start = 1'b0;
            end
        join
        repeat (30) @(negedge clk);
        check_eq("midchg_busy_cycles", busy_cnt - b0, 32'd360);
        check_eq("midchg_done_pulses", done_cnt - d0, 32'd1);
        check_eq("midchg_tx_idle", {31'd0, tx}, 32'd1);

        // 5: start held high gives back-to-back frames with a 5-cycle high gap
        set_ports(p_zero);
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        recv_frame("b2b_1", build_frame(p_zero, 8'h00));
        idx = gap_q.size();
        recv_frame("b2b_2", build_frame(p_zero, 8'h00));
        start = 1'b0;
        check_eq("b2b_gap", (gap_q.size() > idx) ? gap_q[idx] : 32'd0, 32'd5);
        repeat (20) @(negedge clk);
        check_eq("b2b_busy_end", {31'd0, busy}, 32'd0);

        // 6: asynchronous reset mid-frame, then a clean frame
        set_ports(p_seq);
        pulse_start();
        repeat (100) @(negedge clk);
        d0 = done_cnt;
        nreset = 1'b0;
        #1;
        check_eq("arst_tx", {31'd0, tx}, 32'd1);
        check_eq("arst_busy", {31'd0, busy}, 32'd0);
        check_eq("arst_done", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("arst_idle_tx", {31'd0, tx}, 32'd1);
        check_eq("arst_idle_busy", {31'd0, busy}, 32'd0);
        check_eq("arst_no_done", done_cnt - d0, 32'd0);
        set_ports(p_tens);
        pulse_start();
        recv_frame("after_rst", build_frame(p_tens, 8'h40));
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
